// File: rtl/wb_sched_pkg.sv
// wb_sched_pkg: shared state encoding and select-bus layout for the
// write-back port scheduler.
package wb_sched_pkg;
   typedef enum logic [1:0] {
      NORMAL    = 2'd0,
      LSU_BOOST = 2'd1,
      ALU_BOOST = 2'd2
   } sched_state_t;
   localparam int SEL_ALU_LSB = 0;
   localparam int SEL_LSU     = 8;
   localparam int SEL_SALU    = 9;
   localparam int SEL_W       = 16;
endpackage

// File: rtl/wb_port_sched_rr_pick8.sv
// rr_pick8: combinational rotating-priority pick of the first set request
// at or after ptr, wrapping from index 7 to 0.
module rr_pick8 (
   input  logic [7:0] req,
   input  logic [2:0] ptr,
   output logic [7:0] onehot,
   output logic [2:0] idx,
   output logic       any
);
   logic [15:0] dbl;
   logic [7:0]  rot;
   assign any = |req;
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[7:0];
      idx = ptr;
      // rot[k] is req[ptr+k]; scan downward so the lowest offset wins
      for (int k = 7; k >= 0; k--)
         if (rot[k]) idx = ptr + 3'(k);
      onehot = any ? 8'b1 << idx : 8'b0;
   end
endmodule

// File: rtl/wb_port_sched.sv
// wb_port_sched: write-back port scheduler (SALU/LSU/8 ALU queues) with LSU and ALU boost states.
// Defining WB_SCHED_STATS_EN adds grant and boost-entry statistics counters.
module wb_port_sched
   import wb_sched_pkg::*;
#(
   parameter int NUM_ALU      = 8,
   parameter int LSU_MAX_WAIT = 4,
   parameter int ALU_MAX_WAIT = 8,
   parameter int WAIT_CNT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_ALU-1:0] alu_req,
   input  logic               lsu_dest_wr_req,
   input  logic               salu_req,
   output logic [NUM_ALU-1:0] alu_serviced,
   output logic               lsu_wait,
   output logic               salu_wait,
   output logic [SEL_W-1:0]   execvgprsgpr_select_fu
`ifdef WB_SCHED_STATS_EN
   ,
   output logic [31:0]        stat_salu_grants,
   output logic [31:0]        stat_lsu_grants,
   output logic [31:0]        stat_alu_grants,
   output logic [15:0]        stat_boost_entries
`endif
);
   localparam logic [WAIT_CNT_W-1:0] LSU_MAX = WAIT_CNT_W'(LSU_MAX_WAIT);
   localparam logic [WAIT_CNT_W-1:0] ALU_MAX = WAIT_CNT_W'(ALU_MAX_WAIT);
   localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);
   sched_state_t          state, state_next;
   logic [2:0]            rr_ptr;
   logic [WAIT_CNT_W-1:0] lsu_cnt, alu_cnt, lsu_cnt_next, alu_cnt_next;
   logic [7:0]            pick_oh;
   logic [2:0]            pick_idx;
   logic                  pick_any;
   logic                  salu_grant, lsu_grant, alu_grant, lsu_hit, alu_hit;
   rr_pick8 u_pick (
      .req    (alu_req),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );
   // Grants are suppressed entirely while reset is held.
   always_comb begin
      salu_grant = 1'b0;
      lsu_grant  = 1'b0;
      alu_grant  = 1'b0;
      if (rst)
         case (state)
            LSU_BOOST: begin
               lsu_grant  = lsu_dest_wr_req;
               salu_grant = salu_req & ~lsu_dest_wr_req;
               alu_grant  = pick_any & ~lsu_dest_wr_req & ~salu_req;
            end
            ALU_BOOST: begin
               alu_grant  = pick_any;
               salu_grant = salu_req & ~pick_any;
               lsu_grant  = lsu_dest_wr_req & ~pick_any & ~salu_req;
            end
            default: begin
               salu_grant = salu_req;
               lsu_grant  = lsu_dest_wr_req & ~salu_req;
               alu_grant  = pick_any & ~salu_req & ~lsu_dest_wr_req;
            end
         endcase
      lsu_cnt_next = (~lsu_dest_wr_req | lsu_grant) ? '0 :
                     (lsu_cnt == LSU_MAX) ? LSU_MAX : lsu_cnt + CNT_ONE;
      alu_cnt_next = (~pick_any | alu_grant) ? '0 :
                     (alu_cnt == ALU_MAX) ? ALU_MAX : alu_cnt + CNT_ONE;
      lsu_hit = lsu_cnt_next == LSU_MAX;
      alu_hit = alu_cnt_next == ALU_MAX;
      state_next = state;
      case (state)
         LSU_BOOST: if (lsu_grant | ~lsu_dest_wr_req) state_next = alu_hit ? ALU_BOOST : NORMAL;
         ALU_BOOST: if (alu_grant | ~pick_any) state_next = NORMAL;
         default:   state_next = lsu_hit ? LSU_BOOST : alu_hit ? ALU_BOOST : NORMAL;
      endcase
   end
   always_comb begin
      alu_serviced = alu_grant ? pick_oh : '0;
      lsu_wait     = rst & lsu_dest_wr_req & ~lsu_grant;
      salu_wait    = rst & salu_req & ~salu_grant;
      execvgprsgpr_select_fu = '0;
      execvgprsgpr_select_fu[SEL_ALU_LSB +: NUM_ALU] = alu_serviced;
      execvgprsgpr_select_fu[SEL_LSU]  = lsu_grant;
      execvgprsgpr_select_fu[SEL_SALU] = salu_grant;
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state   <= NORMAL;
         rr_ptr  <= '0;
         lsu_cnt <= '0;
         alu_cnt <= '0;
      end else begin
         state   <= state_next;
         lsu_cnt <= lsu_cnt_next;
         alu_cnt <= alu_cnt_next;
         if (alu_grant) rr_ptr <= pick_idx + 3'd1;
      end
`ifdef WB_SCHED_STATS_EN
   always_ff @(posedge clk)
      if (!rst) begin
         stat_salu_grants   <= '0;
         stat_lsu_grants    <= '0;
         stat_alu_grants    <= '0;
         stat_boost_entries <= '0;
      end else begin
         if (salu_grant) stat_salu_grants <= stat_salu_grants + 32'd1;
         if (lsu_grant)  stat_lsu_grants  <= stat_lsu_grants + 32'd1;
         if (alu_grant)  stat_alu_grants  <= stat_alu_grants + 32'd1;
         if ((state_next == LSU_BOOST && state != LSU_BOOST) ||
             (state_next == ALU_BOOST && state != ALU_BOOST))
            stat_boost_entries <= stat_boost_entries + 16'd1;
      end
`endif
endmodule

// File: tb/tb_wb_port_sched.sv
// tb_wb_port_sched: directed test-plan scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural scheduler model.
module tb_wb_port_sched;
   localparam int LMAX = 4;
   localparam int AMAX = 8;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  alu_req;
   logic        lsu_dest_wr_req, salu_req;
   logic [7:0]  alu_serviced;
   logic        lsu_wait, salu_wait;
   logic [15:0] execvgprsgpr_select_fu;
`ifdef WB_SCHED_STATS_EN
   logic [31:0] stat_salu_grants, stat_lsu_grants, stat_alu_grants;
   logic [15:0] stat_boost_entries;
`endif
   int n_tests = 0;
   int n_fail  = 0;
   int m_mode  = 0;
   int m_ptr   = 0;
   int m_lcnt  = 0;
   int m_acnt  = 0;
   logic [15:0] m_sel = '0;
   logic [15:0] obs_sel;
   logic        obs_sw, obs_lw;
   wb_port_sched dut (
      .clk                    (clk),
      .rst                    (rst),
      .alu_req                (alu_req),
      .lsu_dest_wr_req        (lsu_dest_wr_req),
      .salu_req               (salu_req),
      .alu_serviced           (alu_serviced),
      .lsu_wait               (lsu_wait),
      .salu_wait              (salu_wait),
      .execvgprsgpr_select_fu (execvgprsgpr_select_fu)
`ifdef WB_SCHED_STATS_EN
      ,
      .stat_salu_grants       (stat_salu_grants),
      .stat_lsu_grants        (stat_lsu_grants),
      .stat_alu_grants        (stat_alu_grants),
      .stat_boost_entries     (stat_boost_entries)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // One clock cycle: drive inputs, predict and compare at negedge, advance model.
   task automatic cycle(input logic [7:0] a, input logic l, input logic s, input logic r);
      int pick, pri[3];
      logic [15:0] exp_sel;
      logic legal;
      alu_req = a; lsu_dest_wr_req = l; salu_req = s; rst = r;
      @(negedge clk);
      pick = -1;
      for (int k = 0; k < 8; k++)
         if (pick < 0 && a[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
      // source codes: 0 = ALU pick, 1 = LSU, 2 = SALU
      if (m_mode == 1) pri = '{1, 2, 0};
      else if (m_mode == 2) pri = '{0, 2, 1};
      else pri = '{2, 1, 0};
      exp_sel = '0;
      if (r)
         for (int p = 0; p < 3; p++)
            if (exp_sel == 0) begin
               if (pri[p] == 0 && pick >= 0) exp_sel = 16'(1) << pick;
               if (pri[p] == 1 && l) exp_sel = 16'h0100;
               if (pri[p] == 2 && s) exp_sel = 16'h0200;
            end
      obs_sel = execvgprsgpr_select_fu;
      obs_sw  = salu_wait;
      obs_lw  = lsu_wait;
      check("select", obs_sel, exp_sel);
      check("alu_serviced", alu_serviced, exp_sel[7:0]);
      check("lsu_wait", obs_lw, r & l & ~exp_sel[8]);
      check("salu_wait", obs_sw, r & s & ~exp_sel[9]);
      legal = $countones(obs_sel) <= 1 && (obs_sel & {6'b0, s, l, a}) == obs_sel;
      check("onehot_active", legal, 1);
      if (!r) begin
         m_mode = 0; m_ptr = 0; m_lcnt = 0; m_acnt = 0;
      end else begin
         if (|exp_sel[7:0]) m_ptr = (pick + 1) % 8;
         m_lcnt = (!l || exp_sel[8]) ? 0 : (m_lcnt + 1 > LMAX ? LMAX : m_lcnt + 1);
         m_acnt = (a == 0 || |exp_sel[7:0]) ? 0 : (m_acnt + 1 > AMAX ? AMAX : m_acnt + 1);
         if (m_mode == 1) m_mode = (exp_sel[8] || !l) ? (m_acnt == AMAX ? 2 : 0) : 1;
         else if (m_mode == 2) m_mode = (|exp_sel[7:0] || a == 0) ? 0 : 2;
         else m_mode = m_lcnt == LMAX ? 1 : m_acnt == AMAX ? 2 : 0;
      end
      m_sel = exp_sel;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(8'hFF, 1'b1, 1'b1, 1'b0);
         check("reset_outputs", {obs_sel, 6'b0, obs_lw, obs_sw}, 0);
      end
   endtask
   initial begin
      bit seen_lsu, seen_alu;
      logic [7:0] a;
      logic l, s;
      rst = 1'b0; alu_req = '0; lsu_dest_wr_req = 1'b0; salu_req = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         cycle(8'hFF, 1'b0, 1'b0, 1'b1);
         check("rr_rotation", obs_sel, 16'(1) << (i % 8));
      end
      do_reset();
      for (int i = 0; i < 15; i++) begin
         cycle(8'h00, 1'b1, 1'b1, 1'b1);
         check("salu_lsu_pattern", obs_sel, (i % 5 == 4) ? 16'h0100 : 16'h0200);
         check("salu_wait_pattern", obs_sw, i % 5 == 4);
      end
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(8'h01, 1'b1, 1'b0, 1'b1);
         check("alu_boost_bound", obs_sel, (i == 8) ? 16'h0001 : 16'h0100);
      end
      do_reset();
      seen_lsu = 0; seen_alu = 0;
      for (int i = 0; i < 14; i++) begin
         cycle(8'hFF, 1'b1, 1'b1, 1'b1);
         if (obs_sel[8]) seen_lsu = 1;
         if (|obs_sel[7:0]) seen_alu = 1;
      end
      check("all_three_lsu_served", seen_lsu, 1);
      check("all_three_alu_served", seen_alu, 1);
      do_reset();
      for (int i = 0; i < 4; i++) cycle(8'h00, 1'b1, 1'b1, 1'b1);
      cycle(8'h00, 1'b0, 1'b1, 1'b1);
      check("lsu_drop_in_boost", obs_sel, 16'h0200);
      for (int i = 0; i < 5; i++) begin
         cycle(8'h00, 1'b1, 1'b1, 1'b1);
         check("lsu_cnt_cleared", obs_sel, (i == 4) ? 16'h0100 : 16'h0200);
      end
      do_reset();
      for (int i = 0; i < 3; i++) cycle(8'hFF, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) cycle(8'h08, 1'b1, 1'b0, 1'b1);
      cycle(8'h08, 1'b1, 1'b1, 1'b0);
      check("reset_mid_boost", {obs_sel, 6'b0, obs_lw, obs_sw}, 0);
      cycle(8'hFF, 1'b0, 1'b0, 1'b1);
      check("pick_restart_simd0", obs_sel, 16'h0001);
      a = '0; l = 1'b0; s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         a = (a & ~m_sel[7:0] & (($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'hFF))
             | (8'($urandom) & 8'($urandom));
         l = (l & ~m_sel[8] & ($urandom_range(0, 15) != 0)) | ($urandom_range(0, 3) == 0);
         s = (s & ~m_sel[9] & ($urandom_range(0, 15) != 0)) | ($urandom_range(0, 2) == 0);
         cycle(a, l, s, $urandom_range(0, 63) != 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
